// File: rtl/regfile_write_bank.sv
// regfile_write_bank
//   Write side of the CPU register file: a 5-to-32 write decoder, 32 x WIDTH
//   storage, and a sequential clear engine that zeroes one register per cycle.
//   Register ZERO_REG (XZR) always reads as zero.
//
// Parameters
//   WIDTH     data width of each register
//   ZERO_REG  index of the hardwired-zero register
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   wr_en     write request this cycle
//   wr_addr   destination register index
//   wr_data   write data
//   clr_req   start a sequential clear (pulse or level)
//   clr_busy  clear engine active; upstream stalls writes
//   wr_drop   a write request was discarded this cycle (arrived during clear)
//   bank      [31:0][WIDTH-1:0] register contents feeding the read muxes
//
// Configuration
//   REGFILE_WRITE_BYPASS_EN  when defined, an accepted write is forwarded
//                            combinationally onto bank in the same cycle.
module regfile_write_bank #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [4:0]             wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   wr_drop,
    output logic [31:0][WIDTH-1:0] bank
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_ptr;
    logic [31:0][WIDTH-1:0] r_regs;
    logic                   w_wr_ok;
    logic [31:0]            w_wr_sel;
    logic [31:0]            w_clr_sel;

    // Writes are only accepted while idle; XZR is filtered here so it never
    // shows up in the one-hot write select.
    assign w_wr_ok   = wr_en && (r_state == S_IDLE) && (wr_addr != 5'(ZERO_REG));
    assign w_wr_sel  = w_wr_ok ? (32'd1 << wr_addr) : 32'd0;
    assign w_clr_sel = (r_state == S_CLEAR) ? (32'd1 << r_ptr) : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr_req)         w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_ptr == 5'd31)  w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // Pointer sits at 0 while idle, so entering CLEAR starts at register 0;
    // the 31+1 wrap coincides with the return to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 5'd0;
        end else if (r_state == S_CLEAR) begin
            r_ptr <= r_ptr + 5'd1;
        end else begin
            r_ptr <= 5'd0;
        end
    end

    // Write and clear are mutually exclusive by state, so priority is moot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= wr_data;
                end else if (w_clr_sel[i]) begin
                    r_regs[i] <= '0;
                end
            end
        end
    end

    assign clr_busy = (r_state == S_CLEAR);
    assign wr_drop  = wr_en && (r_state == S_CLEAR);

    always_comb begin
        bank = r_regs;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_ok) begin
            bank[wr_addr] = wr_data;
        end
`endif
        bank[ZERO_REG] = '0;
    end

endmodule
